// File: rtl/reg_file_pkg.sv
// Shared constants, data type and physical-address helper for the windowed register file.
package reg_file_pkg;

    localparam int DEF_WIDTH  = 9;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_WIN_AW = 2;

    typedef logic [DEF_WIDTH-1:0] data_t;

    // Window index occupies the upper bits, the field the lower WIN_AW bits; callers truncate.
    function automatic logic [31:0] phys_addr(input logic [31:0] win,
                                              input logic [31:0] field,
                                              input int          win_aw);
        return (win << win_aw) | field;
    endfunction

endpackage

// File: rtl/reg_file_win_if.sv
// Port bundle of the windowed register file; master drives requests, slave returns read data.
interface reg_file_win_if
    import reg_file_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int WIN_AW = DEF_WIN_AW
) ();

    localparam int AW = $clog2(DEPTH);
    localparam int WW = AW - WIN_AW;

    logic              write;
    logic [AW-1:0]     rs_addr;
    logic [WIN_AW-1:0] rt_addr;
    logic [WIN_AW-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_in;
    logic              win_set;
    logic [WW-1:0]     win_idx_in;
    logic              reserve;
    logic [WIN_AW-1:0] reserve_addr;
    logic [WIDTH-1:0]  rs_out;
    logic [WIDTH-1:0]  rt_out;
    logic              rs_busy;
    logic              rt_busy;
    logic [WW-1:0]     win_idx;

    modport master (
        output write, rs_addr, rt_addr, rd_addr, rd_in, win_set, win_idx_in,
               reserve, reserve_addr,
        input  rs_out, rt_out, rs_busy, rt_busy, win_idx
    );

    modport slave (
        input  write, rs_addr, rt_addr, rd_addr, rd_in, win_set, win_idx_in,
               reserve, reserve_addr,
        output rs_out, rt_out, rs_busy, rt_busy, win_idx
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set on reserve, cleared on write, set wins when both hit one register.
module reg_scoreboard #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] a_addr,
    input  logic [AW-1:0] b_addr,
    output logic          a_busy,
    output logic          b_busy
);

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] set_mask_s;
    logic [DEPTH-1:0] clr_mask_s;

    // One-hot masks for the set and clear requests of this cycle.
    always_comb begin
        set_mask_s = {{(DEPTH-1){1'b0}}, set_en} << set_addr;
        clr_mask_s = {{(DEPTH-1){1'b0}}, clr_en} << clr_addr;
    end

    // Busy state update; OR-ing the set mask last makes a new reservation win over a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
        end
    end

    assign a_busy = busy_r[a_addr];
    assign b_busy = busy_r[b_addr];

endmodule

// File: rtl/reg_file_win.sv
// Windowed register file: full-range rs read, windowed rt read and rd write, busy scoreboard.
module reg_file_win
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int WIN_AW   = DEF_WIN_AW,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic clk,
    input  logic reset,
    reg_file_win_if.slave bus
);

    localparam int   AW      = $clog2(DEPTH);
    localparam int   WW      = AW - WIN_AW;
    localparam logic BYP_EN  = (BYPASS != 0);
    localparam logic ZERO_EN = (ZERO_REG != 0);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WW-1:0]    win_idx_r;

    logic [AW-1:0]    rt_pa_s;
    logic [AW-1:0]    rd_pa_s;
    logic [AW-1:0]    rv_pa_s;
    logic             wr_en_s;
    logic             rv_en_s;
    logic             sb_rs_busy_s;
    logic             sb_rt_busy_s;
    logic [WIDTH-1:0] rs_out_s;
    logic [WIDTH-1:0] rt_out_s;
    logic             rs_busy_s;
    logic             rt_busy_s;

    assign rt_pa_s = AW'(phys_addr(32'(win_idx_r), 32'(bus.rt_addr), WIN_AW));
    assign rd_pa_s = AW'(phys_addr(32'(win_idx_r), 32'(bus.rd_addr), WIN_AW));
    assign rv_pa_s = AW'(phys_addr(32'(win_idx_r), 32'(bus.reserve_addr), WIN_AW));

    // Dropping writes/reserves to register 0 also keeps it out of the bypass path.
    assign wr_en_s = bus.write   && !(ZERO_EN && (rd_pa_s == {AW{1'b0}}));
    assign rv_en_s = bus.reserve && !(ZERO_EN && (rv_pa_s == {AW{1'b0}}));

    // Storage array and window index.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            win_idx_r <= {WW{1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_r[rd_pa_s] <= bus.rd_in;
            end
            if (bus.win_set) begin
                win_idx_r <= bus.win_idx_in;
            end
        end
    end

    reg_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (rv_en_s),
        .set_addr (rv_pa_s),
        .clr_en   (wr_en_s),
        .clr_addr (rd_pa_s),
        .a_addr   (bus.rs_addr),
        .b_addr   (rt_pa_s),
        .a_busy   (sb_rs_busy_s),
        .b_busy   (sb_rt_busy_s)
    );

    // Port rs read with optional same-cycle forwarding and zero-register masking.
    always_comb begin
        rs_out_s  = mem_r[bus.rs_addr];
        rs_busy_s = sb_rs_busy_s;
        if (ZERO_EN && (bus.rs_addr == {AW{1'b0}})) begin
            rs_out_s  = {WIDTH{1'b0}};
            rs_busy_s = 1'b0;
        end else if (BYP_EN && wr_en_s && (bus.rs_addr == rd_pa_s)) begin
            rs_out_s  = bus.rd_in;
            rs_busy_s = 1'b0;
        end else begin
            rs_out_s  = mem_r[bus.rs_addr];
            rs_busy_s = sb_rs_busy_s;
        end
    end

    // Port rt read, same rules applied to the windowed address.
    always_comb begin
        rt_out_s  = mem_r[rt_pa_s];
        rt_busy_s = sb_rt_busy_s;
        if (ZERO_EN && (rt_pa_s == {AW{1'b0}})) begin
            rt_out_s  = {WIDTH{1'b0}};
            rt_busy_s = 1'b0;
        end else if (BYP_EN && wr_en_s && (rt_pa_s == rd_pa_s)) begin
            rt_out_s  = bus.rd_in;
            rt_busy_s = 1'b0;
        end else begin
            rt_out_s  = mem_r[rt_pa_s];
            rt_busy_s = sb_rt_busy_s;
        end
    end

    assign bus.rs_out  = rs_out_s;
    assign bus.rt_out  = rt_out_s;
    assign bus.rs_busy = rs_busy_s;
    assign bus.rt_busy = rt_busy_s;
    assign bus.win_idx = win_idx_r;

endmodule

// File: tb/tb_reg_file_win.sv
// Directed bench: three builds (bypass, no bypass, zero register) driven with identical stimulus.
module tb_reg_file_win;

    localparam int WIDTH  = 9;
    localparam int DEPTH  = 16;
    localparam int WIN_AW = 2;

    logic clk;
    logic reset;

    logic       write;
    logic [3:0] rs_addr;
    logic [1:0] rt_addr;
    logic [1:0] rd_addr;
    logic [8:0] rd_in;
    logic       win_set;
    logic [1:0] win_idx_in;
    logic       reserve;
    logic [1:0] reserve_addr;

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bus[0]: BYPASS=1 ZERO_REG=0, bus[1]: BYPASS=0, bus[2]: ZERO_REG=1
    reg_file_win_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WIN_AW(WIN_AW)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].write        = write;
        assign bus[g].rs_addr      = rs_addr;
        assign bus[g].rt_addr      = rt_addr;
        assign bus[g].rd_addr      = rd_addr;
        assign bus[g].rd_in        = rd_in;
        assign bus[g].win_set      = win_set;
        assign bus[g].win_idx_in   = win_idx_in;
        assign bus[g].reserve      = reserve;
        assign bus[g].reserve_addr = reserve_addr;

        reg_file_win #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .WIN_AW   (WIN_AW),
            .BYPASS   ((g == 1) ? 0 : 1),
            .ZERO_REG ((g == 2) ? 1 : 0)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write   = 1'b0;
        win_set = 1'b0;
        reserve = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        idle();
        rs_addr = 4'd0; rt_addr = 2'd0; rd_addr = 2'd0; rd_in = 9'd0;
        win_idx_in = 2'd0; reserve_addr = 2'd0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_eq("rst_rs_out",  32'(bus[0].rs_out),  32'd0);
        check_eq("rst_rt_out",  32'(bus[0].rt_out),  32'd0);
        check_eq("rst_rs_busy", 32'(bus[0].rs_busy), 32'd0);
        check_eq("rst_rt_busy", 32'(bus[0].rt_busy), 32'd0);
        check_eq("rst_win",     32'(bus[0].win_idx), 32'd0);

        // write reg 3 in window 0
        write = 1'b1; rd_addr = 2'd3; rd_in = 9'd255; rs_addr = 4'd3; rt_addr = 2'd3;
        tick();
        idle();
        #1;
        check_eq("wr3_rs", 32'(bus[0].rs_out), 32'd255);
        check_eq("wr3_rt", 32'(bus[0].rt_out), 32'd255);

        // move to window 2 and write field 1 -> physical 9
        win_set = 1'b1; win_idx_in = 2'd2;
        tick();
        idle();
        #1;
        check_eq("win2", 32'(bus[0].win_idx), 32'd2);
        write = 1'b1; rd_addr = 2'd1; rd_in = 9'h1A5;
        tick();
        idle();
        rs_addr = 4'd9; rt_addr = 2'd1;
        #1;
        check_eq("win_rs9", 32'(bus[0].rs_out), 32'h1A5);
        check_eq("win_rt1", 32'(bus[0].rt_out), 32'h1A5);
        rs_addr = 4'd1;
        #1;
        check_eq("win_rs1", 32'(bus[0].rs_out), 32'd0);
        rs_addr = 4'd3;
        #1;
        check_eq("win_rs3", 32'(bus[0].rs_out), 32'd255);

        // same-cycle forwarding to field 2 -> physical 10
        write = 1'b1; rd_addr = 2'd2; rd_in = 9'd77; rt_addr = 2'd2; rs_addr = 4'd10;
        #1;
        check_eq("byp_rt",     32'(bus[0].rt_out), 32'd77);
        check_eq("byp_rs",     32'(bus[0].rs_out), 32'd77);
        check_eq("nobyp_rt_pre", 32'(bus[1].rt_out), 32'd0);
        tick();
        idle();
        #1;
        check_eq("nobyp_rt_post", 32'(bus[1].rt_out), 32'd77);

        // scoreboard on physical 9
        reserve = 1'b1; reserve_addr = 2'd1; rt_addr = 2'd1; rs_addr = 4'd9;
        #1;
        check_eq("rsv_pre", 32'(bus[0].rt_busy), 32'd0);
        tick();
        idle();
        #1;
        check_eq("rsv_rt_busy", 32'(bus[0].rt_busy), 32'd1);
        check_eq("rsv_rs_busy", 32'(bus[0].rs_busy), 32'd1);
        write = 1'b1; rd_addr = 2'd1; rd_in = 9'd5;
        #1;
        check_eq("clr_byp_busy",   32'(bus[0].rt_busy), 32'd0);
        check_eq("clr_nobyp_busy", 32'(bus[1].rt_busy), 32'd1);
        tick();
        idle();
        #1;
        check_eq("clr_busy", 32'(bus[0].rt_busy), 32'd0);
        check_eq("clr_data", 32'(bus[0].rt_out),  32'd5);

        // reserve and write together: data written, busy stays set
        reserve = 1'b1; reserve_addr = 2'd1; write = 1'b1; rd_addr = 2'd1; rd_in = 9'h0AA;
        tick();
        idle();
        #1;
        check_eq("rw_data", 32'(bus[0].rt_out),  32'h0AA);
        check_eq("rw_busy", 32'(bus[0].rt_busy), 32'd1);
        reserve = 1'b1; reserve_addr = 2'd1;
        tick();
        idle();
        #1;
        check_eq("rsv_again", 32'(bus[0].rt_busy), 32'd1);

        // window change with a same-cycle write that lands in the old window
        win_set = 1'b1; win_idx_in = 2'd1; write = 1'b1; rd_addr = 2'd0; rd_in = 9'h123;
        tick();
        idle();
        rs_addr = 4'd8; rt_addr = 2'd0;
        #1;
        check_eq("wc_win",  32'(bus[0].win_idx), 32'd1);
        check_eq("wc_rs8",  32'(bus[0].rs_out),  32'h123);
        check_eq("wc_rt4",  32'(bus[0].rt_out),  32'd0);

        // register 0 in window 0
        win_set = 1'b1; win_idx_in = 2'd0;
        tick();
        idle();
        write = 1'b1; rd_addr = 2'd0; rd_in = 9'd255; reserve = 1'b1; reserve_addr = 2'd0;
        rs_addr = 4'd0; rt_addr = 2'd0;
        #1;
        check_eq("z_pre_rs",   32'(bus[2].rs_out), 32'd0);
        check_eq("nz_pre_rs",  32'(bus[0].rs_out), 32'd255);
        tick();
        idle();
        #1;
        check_eq("z_rs",       32'(bus[2].rs_out),  32'd0);
        check_eq("z_rs_busy",  32'(bus[2].rs_busy), 32'd0);
        check_eq("z_rt",       32'(bus[2].rt_out),  32'd0);
        check_eq("nz_rs",      32'(bus[0].rs_out),  32'd255);
        check_eq("nz_rs_busy", 32'(bus[0].rs_busy), 32'd1);

        // make physical 5 busy with data (9 already is), then reset over pending requests
        win_set = 1'b1; win_idx_in = 2'd1;
        tick();
        idle();
        write = 1'b1; rd_addr = 2'd1; rd_in = 9'h055; reserve = 1'b1; reserve_addr = 2'd1;
        tick();
        idle();
        rs_addr = 4'd5;
        #1;
        check_eq("pre_rst_rs5",   32'(bus[0].rs_out),  32'h055);
        check_eq("pre_rst_busy5", 32'(bus[0].rs_busy), 32'd1);
        rs_addr = 4'd9;
        #1;
        check_eq("pre_rst_busy9", 32'(bus[0].rs_busy), 32'd1);
        reset = 1'b1;
        write = 1'b1; rd_addr = 2'd2; rd_in = 9'h1FF;
        reserve = 1'b1; reserve_addr = 2'd3;
        win_set = 1'b1; win_idx_in = 2'd3;
        tick();
        reset = 1'b0;
        idle();
        rs_addr = 4'd5; rt_addr = 2'd3;
        #1;
        check_eq("post_rst_rs5",   32'(bus[0].rs_out),  32'd0);
        check_eq("post_rst_busy5", 32'(bus[0].rs_busy), 32'd0);
        check_eq("post_rst_rt3",   32'(bus[0].rt_out),  32'd0);
        check_eq("post_rst_win",   32'(bus[0].win_idx), 32'd0);
        rs_addr = 4'd9;
        #1;
        check_eq("post_rst_rs9",   32'(bus[0].rs_out),  32'd0);
        check_eq("post_rst_busy9", 32'(bus[0].rs_busy), 32'd0);
        rs_addr = 4'd15;
        #1;
        check_eq("post_rst_busy15", 32'(bus[0].rs_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_win.md
Name: reg_file_win

Overview:
- Parametrised successor register file for the emulator datapath.
- Two asynchronous read ports:
  - rs: full address space.
  - rt: windowed.
- One synchronous write port, windowed like rt.
- New behaviour:
  - a programmable window base for the rt/rd fields,
  - a per-register busy scoreboard,
  - optional write-to-read bypass,
  - optional hardwired zero register.

Parameters:
- WIDTH, 9, data width of each register.
- DEPTH, 16, number of registers; power of two, at least 2^WIN_AW.
- WIN_AW, 2, address width of the rt/rd fields; window size is 2^WIN_AW.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports.
- ZERO_REG, 0, 1 = physical register 0 reads 0 and ignores writes and reserves.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- write  input  1  write enable for rd.
- rs_addr  input  $clog2(DEPTH)  physical read address, port rs.
- rt_addr  input  WIN_AW  window-relative read address, port rt.
- rd_addr  input  WIN_AW  window-relative write address.
- rd_in  input  WIDTH  write data.
- win_set  input  1  load a new window index.
- win_idx_in  input  $clog2(DEPTH)-WIN_AW  new window index.
- reserve  input  1  mark a register busy.
- reserve_addr  input  WIN_AW  window-relative register to mark busy.
- rs_out  output  WIDTH  read data, port rs.
- rt_out  output  WIDTH  read data, port rt.
- rs_busy  output  1  busy bit of the register addressed by rs.
- rt_busy  output  1  busy bit of the register addressed by rt.
- win_idx  output  $clog2(DEPTH)-WIN_AW  current window index.

Behaviour:
- Physical address of rt, rd and reserve is {win_idx, field}. The window never wraps; it selects an aligned block.
- Reset (synchronous, active-high):
  - all registers 0, all busy bits 0, win_idx 0.
  - Outputs one cycle after reset: rs_out = rt_out = 0, rs_busy = rt_busy = 0.
  - Reset overrides write, reserve and win_set in the same cycle.
  - Reset mid-operation discards pending reservations.
- Write: when write=1 at the rising edge, reg[{win_idx, rd_addr}] <= rd_in and its busy bit clears.
- Read:
  - rs_out = reg[rs_addr]; rt_out = reg[{win_idx, rt_addr}]. Both are combinational, zero latency.
  - rs_busy and rt_busy are likewise combinational from the busy bits.
- Bypass:
  - BYPASS=1, write=1 and the read's physical address equals the write's physical address: that read port outputs rd_in in the same cycle and its busy output reads 0.
  - BYPASS=0: the read returns the old value until after the edge.
- Reserve:
  - reserve=1 sets busy[{win_idx, reserve_addr}] at the edge.
  - Reserve and write to the same physical register in the same cycle: busy ends at 1 (new producer wins); data is still written.
  - Reserve of an already-busy register: busy stays 1, no error.
- Window change:
  - win_set=1 loads win_idx_in at the edge.
  - write and reserve issued in the same cycle use the old win_idx.
  - Reads switch to the new window in the following cycle.
- ZERO_REG=1: physical register 0 always reads 0 with busy 0, and bypass is suppressed for it. Writes and reserves targeting it are dropped.
- No other state; no stall or handshake outputs. The consumer polls the busy outputs.

Decomposition:
- Package reg_file_pkg:
  - default WIDTH / DEPTH / WIN_AW constants,
  - data_t typedef,
  - a function forming the physical address from window index and field.
- Sub-module reg_scoreboard:
  - DEPTH busy bits with set/clear ports and the reserve-wins priority rule,
  - two combinational lookup ports.
- The storage array and the bypass muxes stay in reg_file_win.

Test Plan:
- Reset, then write=1, rd_addr=3, rd_in=255, win_idx=0 for one edge -> rs_addr=3 gives rs_out=255; rt_addr=3 gives rt_out=255.
- win_set=1, win_idx_in=2, then write rd_addr=1, rd_in=9'h1A5 -> rs_addr=9 returns 9'h1A5; rs_addr=1 is unchanged (0).
- BYPASS=1: write rd_addr=2, rd_in=77, with rt_addr=2 in the same cycle -> rt_out=77 before the edge. BYPASS=0 build with the same stimulus -> rt_out=0 before the edge and 77 after.
- Scoreboard:
  - reserve reserve_addr=1 -> rt_busy=1 on the next cycle.
  - write rd_addr=1 -> busy clears.
  - simultaneous reserve and write to register 1 -> data updated and rt_busy=1.
- ZERO_REG=1: write rd_addr=0 at window 0 with rd_in=255 -> rs_addr=0 reads 0 and rs_busy=0.
- Reset asserted while registers 5 and 9 are busy and hold data -> next cycle all reads are 0, all busy bits 0, win_idx=0.
